// File: rtl/sdram_pattern_checker.sv
// Write-then-read SDRAM pattern tester: fills DEPTH words with a selectable
// pattern, reads them back with bounded outstanding reads, and reports errors.
module sdram_pattern_checker #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 12,
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              busy,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t        state;
  logic [1:0]    mode_q;
  logic [CW-1:0] w_idx;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] c_idx;
  logic [OW-1:0] outst;
  logic          wr_fire;
  logic          rd_fire;
  logic          rd_ret;
  logic          mismatch;

  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [CW-1:0] i);
    logic [DATA_W-1:0] p;
    p = '0;
    case (m)
      2'd0:    p = DATA_W'(i) + DATA_W'(1);
      2'd1:    p = ~DATA_W'(i);
      2'd2:    p = DATA_W'(1) << (32'(i) % DATA_W);
      default: p = i[0] ? DATA_W'({((DATA_W + 1) / 2){2'b10}})
                        : DATA_W'({((DATA_W + 1) / 2){2'b01}});
    endcase
    return p;
  endfunction

  // Requests follow busy combinationally so a busy cycle never carries a request.
  assign wr_req  = (state == WRITE) && !busy && (w_idx < CW'(DEPTH));
  assign rd_req  = (state == READ) && !busy && (r_idx < CW'(DEPTH)) &&
                   (outst < OW'(MAX_OUTSTANDING));
  assign wr_addr = ADDR_W'(w_idx);
  assign rd_addr = ADDR_W'(r_idx);
  assign running = (state == WRITE) || (state == READ);

  assign wr_fire  = wr_req && wr_gnt;
  assign rd_fire  = rd_req && rd_gnt;
  assign rd_ret   = (state == READ) && rd_data_valid && (outst != '0);
  assign mismatch = rd_ret && (rd_data != pat(mode_q, c_idx));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mode_q         <= '0;
      w_idx          <= '0;
      r_idx          <= '0;
      c_idx          <= '0;
      outst          <= '0;
      wr_data        <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            state          <= WRITE;
            mode_q         <= mode;
            w_idx          <= '0;
            r_idx          <= '0;
            c_idx          <= '0;
            outst          <= '0;
            wr_data        <= pat(mode, '0);
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
          end
        end

        WRITE: begin
          if (wr_fire) begin
            w_idx   <= w_idx + 1'b1;
            wr_data <= pat(mode_q, w_idx + 1'b1);
            if (w_idx == CW'(DEPTH - 1)) state <= READ;
          end
        end

        READ: begin
          if (rd_fire) r_idx <= r_idx + 1'b1;
          // A grant and a return in the same cycle cancel out.
          if (rd_fire && !rd_ret)      outst <= outst + 1'b1;
          else if (!rd_fire && rd_ret) outst <= outst - 1'b1;
          if (rd_ret) c_idx <= c_idx + 1'b1;
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) begin
              first_err_addr <= ADDR_W'(c_idx);
              first_err_data <= rd_data;
            end
          end
          if (c_idx == CW'(DEPTH)) begin
            state <= FINISH;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Bench for sdram_pattern_checker: three configurations share one controller
// model with random flow control, fault injection and a pattern reference.
module tb_sdram_pattern_checker;
  localparam int DW = 16;
  localparam int AW = 12;

  typedef struct {
    int         sel;
    logic [1:0] mode;
    bit         busy_rand;
    int         dmax;
    int         lat;
    int         c_addr;
    int         c_addr2;
    logic [15:0] c_val;
    bit         zero_all;
    bit         mid_start;
    bit         exp_pass;
    int         exp_err;
    int         exp_fa;
    logic [15:0] exp_fd;
  } vec_t;

  typedef struct { int addr; int due; } rq_t;

  logic          clk;
  logic          reset;
  logic          start_x [3];
  logic [1:0]    mode;
  logic          busy;
  logic          wr_gnt;
  logic          rd_gnt;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;

  logic          wr_req_x [3];
  logic [AW-1:0] wr_addr_x [3];
  logic [DW-1:0] wr_data_x [3];
  logic          rd_req_x [3];
  logic [AW-1:0] rd_addr_x [3];
  logic          running_x [3];
  logic          done_x [3];
  logic          pass_x [3];
  logic [15:0]   err_x [3];
  logic [AW-1:0] fa_x [3];
  logic [DW-1:0] fd_x [3];

  int sel = 0;
  logic          m_wr_req, m_rd_req, m_running, m_done, m_pass;
  logic [AW-1:0] m_wr_addr, m_rd_addr, m_fa;
  logic [DW-1:0] m_wr_data, m_fd;
  logic [15:0]   m_err;

  assign m_wr_req  = wr_req_x[sel];
  assign m_wr_addr = wr_addr_x[sel];
  assign m_wr_data = wr_data_x[sel];
  assign m_rd_req  = rd_req_x[sel];
  assign m_rd_addr = rd_addr_x[sel];
  assign m_running = running_x[sel];
  assign m_done    = done_x[sel];
  assign m_pass    = pass_x[sel];
  assign m_err     = err_x[sel];
  assign m_fa      = fa_x[sel];
  assign m_fd      = fd_x[sel];

  sdram_pattern_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .MAX_OUTSTANDING(4)) u_a (
    .clk(clk), .reset(reset), .start(start_x[0]), .mode(mode), .busy(busy),
    .wr_req(wr_req_x[0]), .wr_gnt(wr_gnt), .wr_addr(wr_addr_x[0]), .wr_data(wr_data_x[0]),
    .rd_req(rd_req_x[0]), .rd_gnt(rd_gnt), .rd_addr(rd_addr_x[0]), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .running(running_x[0]), .done(done_x[0]), .pass(pass_x[0]),
    .err_count(err_x[0]), .first_err_addr(fa_x[0]), .first_err_data(fd_x[0]));

  sdram_pattern_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .reset(reset), .start(start_x[1]), .mode(mode), .busy(busy),
    .wr_req(wr_req_x[1]), .wr_gnt(wr_gnt), .wr_addr(wr_addr_x[1]), .wr_data(wr_data_x[1]),
    .rd_req(rd_req_x[1]), .rd_gnt(rd_gnt), .rd_addr(rd_addr_x[1]), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .running(running_x[1]), .done(done_x[1]), .pass(pass_x[1]),
    .err_count(err_x[1]), .first_err_addr(fa_x[1]), .first_err_data(fd_x[1]));

  sdram_pattern_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .MAX_OUTSTANDING(4)) u_c (
    .clk(clk), .reset(reset), .start(start_x[2]), .mode(mode), .busy(busy),
    .wr_req(wr_req_x[2]), .wr_gnt(wr_gnt), .wr_addr(wr_addr_x[2]), .wr_data(wr_data_x[2]),
    .rd_req(rd_req_x[2]), .rd_gnt(rd_gnt), .rd_addr(rd_addr_x[2]), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .running(running_x[2]), .done(done_x[2]), .pass(pass_x[2]),
    .err_count(err_x[2]), .first_err_addr(fa_x[2]), .first_err_data(fd_x[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference patterns stated arithmetically.
  function automatic int pat_ref(input int m, input int i);
    case (m)
      0:       return (i + 1) % 65536;
      1:       return 65535 - i;
      2:       return 1 << (i % 16);
      default: return (i % 2 == 0) ? 'h5555 : 'hAAAA;
    endcase
  endfunction

  // Controller / memory model state
  int cfg_mode = 0, cfg_dmax = 0, cfg_lat = 1, cfg_c_addr = -1, cfg_c_addr2 = -1;
  bit cfg_busy_rand = 0, cfg_zero = 0;
  logic [15:0] cfg_c_val = '0;
  int depth_now = 16, maxo = 4;
  logic [15:0] mem [4096];
  rq_t q [$];
  int cyc = 0, wn = 0, rn = 0, cn = 0, outst = 0, viol = 0, model_err = 0, sim_cnt = 0;
  int first_gnt = -1, last_gnt = -1, w_cnt = 0, r_cnt = 0;
  bit w_pend = 0, r_pend = 0;
  logic [AW-1:0] w_a = '0;
  logic [DW-1:0] w_d = '0;

  function automatic logic [15:0] resp(input int a);
    if (cfg_zero) return 16'h0000;
    if (a == cfg_c_addr) return cfg_c_val;
    if (a == cfg_c_addr2) return ~cfg_c_val;
    return mem[a];
  endfunction

  always @(negedge clk) begin
    busy = cfg_busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    #1;
    wr_gnt = 1'b0; rd_gnt = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    cyc++;
    if (m_wr_req) begin
      if (!w_pend) begin
        w_pend = 1; w_cnt = int'($urandom_range(0, cfg_dmax)); w_a = m_wr_addr; w_d = m_wr_data;
      end else begin
        check("wr_addr_hold", m_wr_addr, w_a);
        check("wr_data_hold", m_wr_data, w_d);
      end
      if (w_cnt == 0) begin
        wr_gnt = 1'b1; w_pend = 0;
        check("wr_addr", m_wr_addr, wn);
        check("wr_data", m_wr_data, pat_ref(cfg_mode, wn));
        mem[m_wr_addr] = m_wr_data;
        wn++;
      end else w_cnt--;
    end
    if (m_rd_req) begin
      if (!r_pend) begin r_pend = 1; r_cnt = int'($urandom_range(0, cfg_dmax)); end
      if (r_cnt == 0) begin
        rd_gnt = 1'b1; r_pend = 0;
        check("rd_addr", m_rd_addr, rn);
        if (outst >= maxo) viol++;
        q.push_back('{addr: int'(m_rd_addr), due: cyc + cfg_lat});
        rn++;
        if (first_gnt < 0) first_gnt = cyc;
        last_gnt = cyc;
      end else r_cnt--;
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      rd_data_valid = 1'b1;
      rd_data = resp(q[0].addr);
      void'(q.pop_front());
      if (cn < depth_now && int'(rd_data) != pat_ref(cfg_mode, cn)) model_err++;
      cn++;
    end
    if (rd_gnt && rd_data_valid) sim_cnt++;
    outst = outst + int'(rd_gnt) - int'(rd_data_valid);
  end

  task automatic model_clear();
    wn = 0; rn = 0; cn = 0; outst = 0; viol = 0; model_err = 0; sim_cnt = 0;
    w_pend = 0; r_pend = 0; first_gnt = -1; last_gnt = -1;
    q.delete();
  endtask

  task automatic configure(input vec_t v);
    sel = v.sel; cfg_mode = int'(v.mode); cfg_dmax = v.dmax; cfg_lat = v.lat;
    cfg_c_addr = v.c_addr; cfg_c_addr2 = v.c_addr2; cfg_c_val = v.c_val;
    cfg_busy_rand = v.busy_rand; cfg_zero = v.zero_all;
    depth_now = (v.sel == 2) ? 4096 : 16;
    maxo = (v.sel == 1) ? 2 : 4;
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_req"}, m_wr_req, 0);
    check({tag, "_rd_req"}, m_rd_req, 0);
    check({tag, "_running"}, m_running, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_pass"}, m_pass, 0);
    check({tag, "_err"}, m_err, 0);
    check({tag, "_fa"}, m_fa, 0);
    check({tag, "_fd"}, m_fd, 0);
    check({tag, "_wr_addr"}, m_wr_addr, 0);
    check({tag, "_rd_addr"}, m_rd_addr, 0);
    check({tag, "_wr_data"}, m_wr_data, 0);
  endtask

  task automatic run_test(input vec_t v);
    int n;
    configure(v);
    @(negedge clk);
    mode = v.mode;
    start_x[v.sel] = 1'b1;
    @(negedge clk);
    start_x[v.sel] = 1'b0;
    mode = ~v.mode;
    #2;
    check("start_running", m_running, 1);
    check("start_done", m_done, 0);
    check("start_pass", m_pass, 0);
    check("start_err", m_err, 0);
    check("start_fa", m_fa, 0);
    check("start_fd", m_fd, 0);
    if (v.mid_start) begin
      repeat (4) @(negedge clk);
      start_x[v.sel] = 1'b1;
      @(negedge clk);
      start_x[v.sel] = 1'b0;
    end
    n = 0;
    while (!m_done && n < 30000) begin
      @(negedge clk); #2; n++;
    end
    check("done", m_done, 1);
    check("pass", m_pass, v.exp_pass);
    check("err_count", m_err, v.exp_err);
    check("err_vs_model", m_err, model_err);
    check("first_err_addr", m_fa, v.exp_fa);
    check("first_err_data", m_fd, v.exp_fd);
    check("running_end", m_running, 0);
    check("writes", wn, depth_now);
    check("reads", cn, depth_now);
    check("outstanding_limit", viol, 0);
    if (!v.busy_rand && v.dmax == 0 && v.lat < maxo) begin
      check("rd_burst", last_gnt - first_gnt, depth_now - 1);
      check("rd_overlap", sim_cnt, depth_now - v.lat);
    end
  endtask

  initial begin
    vec_t tv [8];
    vec_t clean;
    int n;
    tv[0] = '{sel:0, mode:2'd0, busy_rand:0, dmax:0, lat:3, c_addr:-1, c_addr2:-1, c_val:16'h0,
              zero_all:0, mid_start:1, exp_pass:1, exp_err:0, exp_fa:0, exp_fd:16'h0};
    tv[1] = '{sel:0, mode:2'd2, busy_rand:0, dmax:0, lat:3, c_addr:5, c_addr2:-1, c_val:16'h0,
              zero_all:0, mid_start:0, exp_pass:0, exp_err:1, exp_fa:5, exp_fd:16'h0};
    tv[2] = '{sel:1, mode:2'd3, busy_rand:1, dmax:5, lat:8, c_addr:-1, c_addr2:-1, c_val:16'h0,
              zero_all:0, mid_start:0, exp_pass:1, exp_err:0, exp_fa:0, exp_fd:16'h0};
    tv[3] = '{sel:0, mode:2'd1, busy_rand:0, dmax:0, lat:2, c_addr:-1, c_addr2:-1, c_val:16'h0,
              zero_all:0, mid_start:0, exp_pass:1, exp_err:0, exp_fa:0, exp_fd:16'h0};
    tv[4] = '{sel:0, mode:2'd3, busy_rand:1, dmax:2, lat:4, c_addr:3, c_addr2:9, c_val:16'h0,
              zero_all:0, mid_start:0, exp_pass:0, exp_err:2, exp_fa:3, exp_fd:16'h0};
    tv[5] = '{sel:0, mode:2'd0, busy_rand:0, dmax:0, lat:1, c_addr:15, c_addr2:-1, c_val:16'h1234,
              zero_all:0, mid_start:0, exp_pass:0, exp_err:1, exp_fa:15, exp_fd:16'h1234};
    tv[6] = '{sel:2, mode:2'd1, busy_rand:0, dmax:0, lat:1, c_addr:-1, c_addr2:-1, c_val:16'h0,
              zero_all:1, mid_start:0, exp_pass:0, exp_err:4096, exp_fa:0, exp_fd:16'h0};
    tv[7] = '{sel:2, mode:2'd1, busy_rand:0, dmax:0, lat:1, c_addr:-1, c_addr2:-1, c_val:16'h0,
              zero_all:0, mid_start:0, exp_pass:1, exp_err:0, exp_fa:0, exp_fd:16'h0};
    clean = '{sel:0, mode:2'd0, busy_rand:0, dmax:0, lat:3, c_addr:-1, c_addr2:-1, c_val:16'h0,
              zero_all:0, mid_start:0, exp_pass:1, exp_err:0, exp_fa:0, exp_fd:16'h0};

    reset = 1'b1; mode = 2'd0;
    for (int i = 0; i < 3; i++) start_x[i] = 1'b0;
    repeat (2) @(negedge clk);
    #2 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 check("no_autostart", m_running, 0);

    for (int i = 0; i < 8; i++) run_test(tv[i]);

    // Abort in READ with three reads in flight; late returns carry bad data.
    clean.lat = 8;
    configure(clean);
    @(negedge clk); mode = 2'd0; start_x[0] = 1'b1;
    @(negedge clk); start_x[0] = 1'b0;
    n = 0;
    while (!(outst == 3 && wn == 16) && n < 500) begin
      @(negedge clk); #2; n++;
    end
    check("reach_outstanding3", outst, 3);
    @(posedge clk); #1;
    reset = 1'b1; cfg_zero = 1; w_pend = 0; r_pend = 0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #2 check_zero("after_late_valid");

    clean.lat = 3;
    run_test(clean);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
